button_slave: RTL and testbench
===============================

BUTTON_SLAVE -- requirements
Module: button_slave

Interface
REQ-001 Parameters SHALL be DEBOUNCE_CYCLES, default 1000, the number of stable cycles required to accept a level change (range 2..65535).
REQ-002 Parameter BUTTON_ADDR SHALL default to 411700, the single word address decoded by this slave.
REQ-003 Port clock: input, 1 bit, single system clock; all state updates on its rising edge.
REQ-004 Port reset: input, 1 bit, reset that is synchronous and active-high.
REQ-005 Port button: input, 1 bit, raw asynchronous push-button level, 1 = pressed.
REQ-006 Port addr: input, 32 bits, word address from the write-back bus slave port.
REQ-007 Port wdata: input, 32 bits, write data from the bus.
REQ-008 Port write: input, 1 bit, write strobe from the bus, qualified by addr.
REQ-009 Port rdata: output, 32 bits, status word returned to the bus.
REQ-010 Port irq: output, 1 bit, level copy of the pending flag.

Function
REQ-011 button SHALL pass through a 2-flop synchronizer before any other logic; sync latency is 2 cycles.
REQ-012 The debounce FSM SHALL have the states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-013 In IDLE, a synced level of 1 SHALL move the FSM to PRESS_WAIT and load the stability counter with 1.
REQ-014 In PRESS_WAIT, a synced level of 1 SHALL increment the counter, and a level of 0 SHALL return the FSM to IDLE (glitch rejected).
REQ-015 When the counter reaches DEBOUNCE_CYCLES in PRESS_WAIT, the FSM SHALL enter PRESSED and assert a one-cycle press event.
REQ-016 PRESSED to RELEASE_WAIT to IDLE SHALL be symmetric, using a synced level of 0 and the same count; no event is generated on release.
REQ-017 The debounced level SHALL be 1 in PRESSED and RELEASE_WAIT, and 0 in IDLE and PRESS_WAIT.
REQ-018 On a press event, the pending flag SHALL set and press_count (8 bits) SHALL increment, wrapping 255 to 0.
REQ-019 rdata SHALL be combinational and, when addr == BUTTON_ADDR, carry {16'b0, press_count[7:0], 6'b0, debounced, pending}; for any other addr it SHALL be 0.
REQ-020 A write with write = 1 and addr == BUTTON_ADDR SHALL take effect on the next edge as follows.
REQ-020a If wdata[0] = 1, the write SHALL clear pending.
REQ-020b If wdata[1] = 1, the write SHALL clear press_count.
REQ-020c All other wdata bits SHALL be ignored.
REQ-021 A write with addr != BUTTON_ADDR SHALL have no effect.
REQ-022 If a press event and a pending-clear occur in the same cycle, pending SHALL remain 1 (the event is not lost).
REQ-023 If a press event and a count-clear occur in the same cycle, press_count SHALL become 1.
REQ-024 A read SHALL have no side effects.
REQ-025 irq SHALL equal pending, with no additional latency.
REQ-026 The stability counter SHALL be sized to ceil(log2(DEBOUNCE_CYCLES+1)) bits and SHALL never exceed DEBOUNCE_CYCLES.

Reset
REQ-027 While reset = 1 at a clock edge, the following SHALL hold.
REQ-027a The FSM SHALL be in IDLE.
REQ-027b The counter, pending, press_count and both synchronizer flops SHALL be 0.
REQ-027c irq SHALL be 0.
REQ-027d rdata SHALL be 0 for any addr, or {16'b0, 8'b0, 6'b0, 0, 0} when addr == BUTTON_ADDR.
REQ-028 Reset asserted mid-debounce SHALL abandon the debounce with no event generated.
REQ-029 A button held down through reset release SHALL require the full 2 + DEBOUNCE_CYCLES cycles before its press event.

Structure
REQ-030 The address map constants SHALL live in the shared package soc_pkg: RAM_TOP = 206800, DUALRAM_TOP = 411700, BUTTON_ADDR = 411700.
REQ-031 The FSM state enum (btn_state_t) SHALL also live in soc_pkg.
REQ-032 The synchronizer plus debounce FSM SHALL be one sub-module, button_debounce, whose outputs are the debounced level and the press event.
REQ-033 button_slave SHALL contain the register file and address decode only.

Verification (DEBOUNCE_CYCLES = 4)
REQ-034 After reset, hold button at 1 for 10 cycles, then read 411700 -> pending = 1, debounced = 1, press_count = 1, irq = 1; the event fires exactly 6 cycles after the rising input.
REQ-035 Apply 3-cycle pulses of button = 1 separated by 3 cycles of 0, 5 times -> no event, and rdata = 0x00000000.
REQ-036 Perform 256 clean presses -> press_count = 0 (wrap), pending = 1; then write wdata = 0x3 -> rdata = 0x00000000 with the button released.
REQ-037 Write wdata = 0x1 in the exact cycle of a press event -> pending stays 1 and press_count increments.
REQ-038 Write wdata = 0x1 to address 411699, and separately read address 0 -> pending is unchanged and rdata = 0.
REQ-039 Assert reset 2 cycles into PRESS_WAIT while holding button at 1 -> no event; after release of reset the event fires 6 cycles later.

Source files
------------

// File: rtl/soc_pkg.sv
// Shared SoC address map and the button debounce state encoding.
package soc_pkg;

   localparam int unsigned RAM_TOP     = 206800;
   localparam int unsigned DUALRAM_TOP = 411700;
   localparam int unsigned BUTTON_ADDR = 411700;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } btn_state_t;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a symmetric press/release debounce FSM.
// Emits the debounced level and a one-cycle pulse on each accepted press.
module button_debounce
   import soc_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
   input  logic clock,
   input  logic reset,
   input  logic button_i,
   output logic debounced_o,
   output logic press_o
);

   localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   btn_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         sync1_q <= button_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The counter holds the number of stable samples seen so far; the sample
   // that would bring it to DEBOUNCE_CYCLES commits the transition instead.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (sync2_q) begin
               state_d = PRESS_WAIT;
               cnt_d   = CNT_ONE;
            end
         end
         PRESS_WAIT: begin
            if (!sync2_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = PRESSED;
               cnt_d   = '0;
               press_o = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         PRESSED: begin
            if (!sync2_q) begin
               state_d = RELEASE_WAIT;
               cnt_d   = CNT_ONE;
            end
         end
         RELEASE_WAIT: begin
            if (sync2_q) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign debounced_o = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/button_slave.sv
// Bus slave exposing the debounced push button: pending flag, press counter
// and interrupt, with write-one-to-clear control at a single word address.
module button_slave
   import soc_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter int unsigned BUTTON_ADDR     = soc_pkg::BUTTON_ADDR
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        button,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        write,
   output logic [31:0] rdata,
   output logic        irq
);

   localparam logic [31:0] ADDR_MATCH = 32'(BUTTON_ADDR);

   logic       debounced, press;
   logic       hit, wr_en;
   logic       pending_q, pending_d;
   logic [7:0] count_q, count_d;
   logic       wdata_unused;

   button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clock      (clock),
      .reset      (reset),
      .button_i   (button),
      .debounced_o(debounced),
      .press_o    (press)
   );

   assign hit          = (addr == ADDR_MATCH);
   assign wr_en        = write && hit;
   assign wdata_unused = ^wdata[31:2];

   // A press in the same cycle as a clear wins, so no event is ever lost.
   always_comb begin
      pending_d = pending_q;
      count_d   = count_q;
      if (press) begin
         pending_d = 1'b1;
      end else if (wr_en && wdata[0]) begin
         pending_d = 1'b0;
      end
      if (wr_en && wdata[1]) begin
         count_d = press ? 8'd1 : 8'd0;
      end else if (press) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pending_q <= 1'b0;
         count_q   <= 8'd0;
      end else begin
         pending_q <= pending_d;
         count_q   <= count_d;
      end
   end

   assign rdata = hit ? {16'h0000, count_q, 6'b000000, debounced, pending_q} : 32'h0000_0000;
   assign irq   = pending_q;

endmodule

// File: tb/tb_button_slave.sv
// Randomized and directed bench for button_slave with a run-length reference
// model and a read scoreboard drained by an independent monitor.
module tb_button_slave;
   import soc_pkg::*;

   localparam int unsigned D  = 4;
   localparam logic [31:0] BA = 32'(BUTTON_ADDR);

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        button = 1'b0;
   logic        write = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic        irq;

   always #5 clock = ~clock;

   button_slave #(
      .DEBOUNCE_CYCLES(D),
      .BUTTON_ADDR    (BUTTON_ADDR)
   ) dut (
      .clock(clock),
      .reset(reset),
      .button(button),
      .addr (addr),
      .wdata(wdata),
      .write(write),
      .rdata(rdata),
      .irq  (irq)
   );

   typedef struct packed {
      logic [31:0] rd;
      logic        irq;
      logic [31:0] id;
      logic [31:0] a;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   txn = 0;
   bit   rd_valid = 1'b0;

   // Reference model: the synced level must differ from the accepted level
   // for D consecutive samples before it is accepted.
   bit m_s1, m_s2, m_deb, m_pend;
   int m_run, m_cnt;

   always @(posedge clock) begin
      bit evt, wr;
      if (reset) begin
         m_s1 = 0; m_s2 = 0; m_deb = 0; m_pend = 0; m_run = 0; m_cnt = 0;
      end else begin
         evt = 0;
         if (m_s2 != m_deb) begin
            m_run++;
            if (m_run == D) begin
               m_deb = m_s2;
               m_run = 0;
               evt   = m_s2;
            end
         end else begin
            m_run = 0;
         end
         wr = write && (addr == BA);
         if (wr && wdata[1]) m_cnt = evt ? 1 : 0;
         else if (evt)       m_cnt = (m_cnt + 1) % 256;
         if (evt)                 m_pend = 1;
         else if (wr && wdata[0]) m_pend = 0;
         m_s2 = m_s1;
         m_s1 = button;
      end
   end

   function automatic bit evt_next();
      return m_s2 && !m_deb && (m_run == D - 1);
   endfunction

   function automatic exp_t expect_for(input logic [31:0] a);
      exp_t e;
      logic [7:0] c;
      c    = 8'(m_cnt);
      e.rd = (a == BA) ? {16'h0, c, 6'h0, m_deb, m_pend} : 32'h0;
      e.irq = m_pend;
      e.id  = 32'(txn);
      e.a   = a;
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic b, input logic rst, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd, input bit rd);
      @(negedge clock);
      button = b; reset = rst; write = wr; addr = a; wdata = wd;
      rd_valid = rd;
      if (rd) begin
         exp_q.push_back(expect_for(a));
         txn++;
      end
   endtask

   // Monitor: samples away from the active edge whenever a read is presented.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         #2;
         if (rd_valid) begin
            if (exp_q.size() == 0) begin
               check("scoreboard_underflow", 32'd0, 32'd1);
            end else begin
               e = exp_q.pop_front();
               $display("read %0d addr=%0d rdata=%h irq=%b", e.id, e.a, rdata, irq);
               check("rdata", rdata, e.rd);
               check("irq", 32'(irq), 32'(e.irq));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit fired;
      int guard;
      int hold;
      logic b, rst, wr, rd;
      logic [31:0] a, wd;

      // Reset state, at the slave address and elsewhere.
      repeat (3) step(0, 1, 0, BA, 32'h0, 1);
      step(0, 1, 0, 32'h0, 32'h0, 1);
      #2 check("reset_rdata", rdata, 32'h0);

      // Clean press: event lands on the sixth edge after the rising input.
      for (int k = 0; k < 10; k++) begin
         step(1, 0, 0, BA, 32'h0, 1);
         #2 check("press_timing_irq", 32'(irq), 32'(k >= 6));
      end
      step(1, 0, 0, BA, 32'h0, 1);
      #2 check("press_rdata", rdata, 32'h0000_0103);
      repeat (10) step(0, 0, 0, BA, 32'h0, 0);
      step(0, 0, 0, BA, 32'h0, 1);
      #2 check("released_rdata", rdata, 32'h0000_0101);
      step(0, 0, 1, BA, 32'h3, 0);
      step(0, 0, 0, BA, 32'h0, 1);
      #2 check("clear_rdata", rdata, 32'h0);

      // Short pulses are rejected.
      repeat (5) begin
         repeat (3) step(1, 0, 0, BA, 32'h0, 0);
         repeat (3) step(0, 0, 0, BA, 32'h0, 0);
      end
      repeat (6) step(0, 0, 0, BA, 32'h0, 0);
      step(0, 0, 0, BA, 32'h0, 1);
      #2 check("glitch_rdata", rdata, 32'h0);

      // 256 presses wrap the counter.
      for (int i = 0; i < 256; i++) begin
         repeat (D + 3) step(1, 0, 0, BA, 32'h0, 0);
         repeat (D + 3) step(0, 0, 0, BA, 32'h0, 0);
      end
      step(0, 0, 0, BA, 32'h0, 1);
      #2 check("wrap_rdata", rdata, 32'h0000_0001);
      step(0, 0, 1, BA, 32'h3, 0);
      step(0, 0, 0, BA, 32'h0, 1);
      #2 check("wrap_clear_rdata", rdata, 32'h0);

      // Pending-clear in the exact cycle of the press event.
      fired = 0;
      guard = 0;
      while (!fired && guard < 20) begin
         @(negedge clock);
         fired = evt_next();
         button = 1; reset = 0; addr = BA; wdata = 32'h1; write = fired;
         rd_valid = 0;
         guard++;
      end
      check("collide_found", 32'(fired), 32'd1);
      step(1, 0, 0, BA, 32'h0, 1);
      #2 check("collide_rdata", rdata, 32'h0000_0103);
      repeat (8) step(0, 0, 0, BA, 32'h0, 0);

      // Writes to another address are ignored; other addresses read zero.
      step(0, 0, 1, BA - 32'd1, 32'h1, 0);
      step(0, 0, 0, BA, 32'h0, 1);
      #2 check("miss_write_rdata", rdata, 32'h0000_0101);
      step(0, 0, 0, 32'h0, 32'h0, 1);
      #2 check("other_addr_rdata", rdata, 32'h0);

      // Reset in the middle of PRESS_WAIT abandons the debounce.
      step(0, 0, 1, BA, 32'h3, 0);
      guard = 0;
      step(1, 0, 0, BA, 32'h0, 0);
      while (!(m_run == 2 && !m_deb) && guard < 20) begin
         step(1, 0, 0, BA, 32'h0, 0);
         guard++;
      end
      check("midwait_found", 32'(m_run), 32'd2);
      repeat (2) step(1, 1, 0, BA, 32'h0, 1);
      for (int k = 0; k < 10; k++) begin
         step(1, 0, 0, BA, 32'h0, 1);
         #2 check("restart_timing_irq", 32'(irq), 32'(k >= 6));
      end
      repeat (8) step(0, 0, 0, BA, 32'h0, 0);

      // Randomized traffic.
      hold = 0;
      b = 0;
      for (int i = 0; i < 800; i++) begin
         if (hold == 0) begin
            b = ~b;
            hold = $urandom_range(1, 9);
         end
         hold--;
         rst = ($urandom_range(0, 99) == 0);
         wr  = ($urandom_range(0, 7) == 0);
         a   = ($urandom_range(0, 3) != 0) ? BA : $urandom;
         wd  = $urandom;
         rd  = ($urandom_range(0, 1) == 1);
         step(b, rst, wr, a, wd, rd);
      end

      step(0, 0, 0, 32'h0, 32'h0, 0);
      step(0, 0, 0, 32'h0, 32'h0, 0);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
